// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multicycle ARM-subset datapath.
// Control-field values, register indices and a rotate helper.
package multicycle_datapath_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_MOV = 3'b100,
      ALU_MVN = 3'b101,
      ALU_EOR = 3'b110,
      ALU_RSB = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCA_PC   = 2'b00,
      SRCA_A    = 2'b01,
      SRCA_ZERO = 2'b10
   } src_a_e;

   typedef enum logic [1:0] {
      SRCB_SHIFT = 2'b00,
      SRCB_IMM   = 2'b01,
      SRCB_ZERO  = 2'b10,
      SRCB_ONE   = 2'b11
   } src_b_e;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_DATA   = 2'b01,
      RES_ALU    = 2'b10
   } res_src_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   localparam logic [3:0] R15 = 4'd15;
   localparam logic [3:0] R14 = 4'd14;

   function automatic logic [31:0] ror32(
      input logic [31:0] v,
      input logic [4:0]  n
   );
      logic [63:0] d;
      d = {v, v} >> n;
      return d[31:0];
   endfunction

endpackage

// File: rtl/multicycle_alu.sv
// 32-bit ALU producing NZCV; carry for logical ops comes from the shifter.
// RSB reuses the subtract path with the operands swapped.
module multicycle_alu
   import multicycle_datapath_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic        cin,
   output logic [31:0] y,
   output logic [3:0]  nzcv
);

   logic [31:0] x;
   logic [31:0] z;
   logic        cy;
   logic [32:0] sum;
   logic        c;
   logic        v;

   always_comb begin
      x  = a;
      z  = b;
      cy = 1'b0;
      unique case (op)
         ALU_SUB: begin
            z  = ~b;
            cy = 1'b1;
         end
         ALU_RSB: begin
            x  = b;
            z  = ~a;
            cy = 1'b1;
         end
         default: ;
      endcase
   end

   assign sum = {1'b0, x} + {1'b0, z} + {32'd0, cy};

   always_comb begin
      y = sum[31:0];
      c = cin;
      v = 1'b0;
      unique case (op)
         ALU_ADD, ALU_SUB, ALU_RSB: begin
            y = sum[31:0];
            c = sum[32];
            v = (x[31] == z[31]) && (sum[31] != x[31]);
         end
         ALU_AND: y = a & b;
         ALU_ORR: y = a | b;
         ALU_MOV: y = b;
         ALU_MVN: y = ~b;
         ALU_EOR: y = a ^ b;
         default: y = sum[31:0];
      endcase
   end

   assign nzcv = {y[31], (y == 32'd0), c, v};

endmodule

// File: rtl/multicycle_datapath.sv
// Controller-less ARM-subset multicycle datapath with unified memory.
// Every mux select and enable is driven from outside.
module multicycle_datapath
   import multicycle_datapath_pkg::*;
#(
   parameter int    MEM_DEPTH = 256,
   parameter string MEM_FILE  = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        AdrSrc,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [1:0]  RegSrc,
   input  logic        RegWrite,
   input  logic        A3Src,
   input  logic        WD3Src,
   input  logic [1:0]  ALUSrcA,
   input  logic [1:0]  ALUSrcB,
   input  logic [2:0]  ALUop,
   input  logic [1:0]  ResultSrc,
   input  logic        FlagUpdate,
   output logic [31:0] INSTRUCTION_OUT,
   output logic [3:0]  FLAGS,
   output logic [7:0]  R0_out,
   output logic [7:0]  R1_out
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic [31:0] mem [MEM_DEPTH];
   logic [31:0] rf  [15];

   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] a_reg;
   logic [31:0] wd_reg;
   logic [31:0] alu_out;
   logic [31:0] data;
   logic [3:0]  flags;

   logic [3:0]  ra1;
   logic [3:0]  ra2;
   logic [3:0]  a3;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] wd3;
   logic [31:0] adr;
   logic [31:0] rd_mem;
   logic [31:0] result;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] ext_imm;
   logic [31:0] sh_val;
   logic        sh_c;
   logic [4:0]  sh_amt;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;

   assign ra1 = RegSrc[0] ? R15 : instr[19:16];
   assign ra2 = RegSrc[1] ? instr[15:12] : instr[3:0];
   assign a3  = A3Src ? R14 : instr[15:12];
   assign wd3 = WD3Src ? pc : result;

   // R15 reads see the already-incremented PC plus one
   assign rd1 = (ra1 == R15) ? pc + 32'd1 : rf[ra1];
   assign rd2 = (ra2 == R15) ? pc + 32'd1 : rf[ra2];

   assign adr    = AdrSrc ? result : pc;
   assign rd_mem = mem[adr[AW-1:0]];

   assign sh_amt = instr[11:7];

   always_comb begin
      sh_val = wd_reg;
      sh_c   = flags[1];
      if (instr[27:25] == 3'b000 && sh_amt != 5'd0) begin
         unique case (instr[6:5])
            SH_LSL: {sh_c, sh_val} = {1'b0, wd_reg} << sh_amt;
            SH_LSR: {sh_val, sh_c} = {wd_reg, 1'b0} >> sh_amt;
            SH_ASR: {sh_val, sh_c} = $signed({wd_reg, 1'b0}) >>> sh_amt;
            SH_ROR: begin
               sh_val = ror32(wd_reg, sh_amt);
               sh_c   = sh_val[31];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      unique case (instr[27:26])
         2'b01:   ext_imm = {20'd0, instr[11:0]};
         2'b00:   ext_imm = ror32({24'd0, instr[7:0]},
                                  {instr[11:8], 1'b0});
         default: ext_imm = {{8{instr[23]}}, instr[23:0]};
      endcase
   end

   always_comb begin
      unique case (ALUSrcA)
         SRCA_PC: src_a = pc;
         SRCA_A:  src_a = a_reg;
         default: src_a = 32'd0;
      endcase
   end

   always_comb begin
      unique case (ALUSrcB)
         SRCB_SHIFT: src_b = sh_val;
         SRCB_IMM:   src_b = ext_imm;
         SRCB_ZERO:  src_b = 32'd0;
         default:    src_b = 32'd1;
      endcase
   end

   multicycle_alu u_alu (
      .a    (src_a),
      .b    (src_b),
      .op   (ALUop),
      .cin  (sh_c),
      .y    (alu_result),
      .nzcv (alu_flags)
   );

   always_comb begin
      unique case (ResultSrc)
         RES_ALUOUT: result = alu_out;
         RES_DATA:   result = data;
         default:    result = alu_result;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= '0;
         instr   <= '0;
         a_reg   <= '0;
         wd_reg  <= '0;
         alu_out <= '0;
         data    <= '0;
         flags   <= '0;
         for (int i = 0; i < 15; i++) rf[i] <= '0;
      end else begin
         a_reg   <= rd1;
         wd_reg  <= rd2;
         alu_out <= alu_result;
         data    <= rd_mem;
         if (IRWrite)    instr <= rd_mem;
         if (PCWrite)    pc    <= result;
         if (FlagUpdate) flags <= alu_flags;
         if (RegWrite && a3 != R15) rf[a3] <= wd3;
      end
   end

   // Memory content survives reset
   always_ff @(posedge clock) begin
      if (MemWrite) mem[adr[AW-1:0]] <= wd_reg;
   end

   logic unused_bits;
   assign unused_bits = ^{instr[31:28], instr[24], adr[31:AW]};

   assign INSTRUCTION_OUT = instr;
   assign FLAGS           = flags;
   assign R0_out          = rf[0][7:0];
   assign R1_out          = rf[1][7:0];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with an architectural model.
// Memory is loaded through the datapath itself before the program runs.
module tb_multicycle_datapath;

   typedef struct packed {
      logic       pcw;
      logic       adrs;
      logic       memw;
      logic       irw;
      logic [1:0] regsrc;
      logic       regw;
      logic       a3s;
      logic       wd3s;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [2:0] op;
      logic [1:0] ress;
      logic       flagu;
   } ctl_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   ctl_t        ctl   = '0;
   logic [31:0] instr_o;
   logic [3:0]  flags_o;
   logic [7:0]  r0_o;
   logic [7:0]  r1_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_pc, m_instr, m_a, m_wd, m_aluout, m_data;
   logic [31:0] m_rf  [16];
   logic [31:0] m_mem [256];
   logic [3:0]  m_flags;

   always #5 clock = ~clock;

   multicycle_datapath #(.MEM_DEPTH(256), .MEM_FILE("")) dut (
      .clock           (clock),
      .reset           (reset),
      .PCWrite         (ctl.pcw),
      .AdrSrc          (ctl.adrs),
      .MemWrite        (ctl.memw),
      .IRWrite         (ctl.irw),
      .RegSrc          (ctl.regsrc),
      .RegWrite        (ctl.regw),
      .A3Src           (ctl.a3s),
      .WD3Src          (ctl.wd3s),
      .ALUSrcA         (ctl.srca),
      .ALUSrcB         (ctl.srcb),
      .ALUop           (ctl.op),
      .ResultSrc       (ctl.ress),
      .FlagUpdate      (ctl.flagu),
      .INSTRUCTION_OUT (instr_o),
      .FLAGS           (flags_o),
      .R0_out          (r0_o),
      .R1_out          (r1_o)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- architectural model ----------------
   function automatic logic [31:0] rf_rd(input logic [3:0] i);
      return (i == 4'd15) ? m_pc + 32'd1 : m_rf[i];
   endfunction

   function automatic logic [31:0] ext_m(input logic [31:0] ins);
      logic [31:0] imm8;
      int          rot;
      imm8 = {24'd0, ins[7:0]};
      rot  = 2 * int'(ins[11:8]);
      case (ins[27:26])
         2'b01:   return {20'd0, ins[11:0]};
         2'b00:   return (imm8 >> rot) | (imm8 << (32 - rot));
         default: return {{8{ins[23]}}, ins[23:0]};
      endcase
   endfunction

   task automatic sh_m(input logic [31:0] ins, input logic [31:0] wd,
                       input logic cin,
                       output logic [31:0] r, output logic c);
      int n;
      n = int'(ins[11:7]);
      r = wd;
      c = cin;
      if (ins[27:25] == 3'b000 && n != 0) begin
         case (ins[6:5])
            2'd0: begin r = wd << n; c = wd[32 - n]; end
            2'd1: begin r = wd >> n; c = wd[n - 1]; end
            2'd2: begin r = $signed(wd) >>> n; c = wd[n - 1]; end
            default: begin
               r = (wd >> n) | (wd << (32 - n));
               c = wd[n - 1];
            end
         endcase
      end
   endtask

   task automatic alu_m(input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic cin,
                        output logic [31:0] r, output logic [3:0] f);
      longint unsigned ua, ub;
      longint          sa, sb, s;
      logic            c, arith;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      s = 0; c = cin; arith = 1'b1;
      case (op)
         3'd0: begin r = a + b; s = sa + sb; c = (ua + ub) > 64'hFFFF_FFFF; end
         3'd1: begin r = a - b; s = sa - sb; c = ua >= ub; end
         3'd7: begin r = b - a; s = sb - sa; c = ub >= ua; end
         default: begin
            arith = 1'b0;
            case (op)
               3'd2:    r = a & b;
               3'd3:    r = a | b;
               3'd4:    r = b;
               3'd5:    r = ~b;
               default: r = a ^ b;
            endcase
         end
      endcase
      f = {r[31], r == 32'd0, c,
           arith && (s > 64'sd2147483647 || s < -64'sd2147483648)};
   endtask

   task automatic model_step();
      logic [31:0] rd1, rd2, sh, sa, sb, alu_r, result, adr, mrd;
      logic [3:0]  alu_f, a3;
      logic        shc;
      if (reset) begin
         m_pc <= '0; m_instr <= '0; m_a <= '0; m_wd <= '0;
         m_aluout <= '0; m_data <= '0; m_flags <= '0;
         for (int i = 0; i < 16; i++) m_rf[i] <= '0;
      end else begin
         rd1 = rf_rd(ctl.regsrc[0] ? 4'd15 : m_instr[19:16]);
         rd2 = rf_rd(ctl.regsrc[1] ? m_instr[15:12] : m_instr[3:0]);
         sh_m(m_instr, m_wd, m_flags[1], sh, shc);
         sa = ctl.srca[1] ? 32'd0 : (ctl.srca[0] ? m_a : m_pc);
         case (ctl.srcb)
            2'd0:    sb = sh;
            2'd1:    sb = ext_m(m_instr);
            2'd2:    sb = 32'd0;
            default: sb = 32'd1;
         endcase
         alu_m(ctl.op, sa, sb, shc, alu_r, alu_f);
         result = ctl.ress[1] ? alu_r : (ctl.ress[0] ? m_data : m_aluout);
         adr = ctl.adrs ? result : m_pc;
         mrd = m_mem[adr[7:0]];
         a3  = ctl.a3s ? 4'd14 : m_instr[15:12];
         m_a <= rd1; m_wd <= rd2; m_aluout <= alu_r; m_data <= mrd;
         if (ctl.irw)   m_instr <= mrd;
         if (ctl.pcw)   m_pc    <= result;
         if (ctl.flagu) m_flags <= alu_f;
         if (ctl.memw)  m_mem[adr[7:0]] <= m_wd;
         if (ctl.regw && a3 != 4'd15)
            m_rf[a3] <= ctl.wd3s ? m_pc : result;
      end
   endtask

   always @(posedge clock) model_step();

   always @(negedge clock) begin
      if (chk_en) begin
         check("instr", instr_o, m_instr);
         check("flags", 32'(flags_o), 32'(m_flags));
         check("r0", 32'(r0_o), 32'(m_rf[0][7:0]));
         check("r1", 32'(r1_o), 32'(m_rf[1][7:0]));
         check("pc", dut.pc, m_pc);
      end
   end

   // ---------------- control presets ----------------
   function automatic ctl_t c_fetch();
      ctl_t c = '0;
      c.irw = 1'b1; c.pcw = 1'b1; c.srcb = 2'b11; c.ress = 2'b10;
      return c;
   endfunction
   function automatic ctl_t c_dec(input logic [1:0] rs);
      ctl_t c = '0;
      c.regsrc = rs;
      return c;
   endfunction
   function automatic ctl_t c_memadr(input logic [1:0] rs);
      ctl_t c = '0;
      c.srca = 2'b01; c.srcb = 2'b01; c.regsrc = rs;
      return c;
   endfunction
   function automatic ctl_t c_memrd();
      ctl_t c = '0;
      c.adrs = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_ldwb();
      ctl_t c = '0;
      c.ress = 2'b01; c.regw = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_exec(input logic [2:0] op,
                                   input logic [1:0] srcb,
                                   input logic fu);
      ctl_t c = '0;
      c.srca = 2'b01; c.srcb = srcb; c.op = op; c.flagu = fu;
      return c;
   endfunction
   function automatic ctl_t c_dpwb();
      ctl_t c = '0;
      c.regw = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_store(input logic [1:0] rs);
      ctl_t c = '0;
      c.adrs = 1'b1; c.memw = 1'b1; c.regsrc = rs;
      return c;
   endfunction
   function automatic ctl_t c_r0(input logic [1:0] srca,
                                 input logic [1:0] srcb);
      ctl_t c = '0;
      c.srca = srca; c.srcb = srcb; c.ress = 2'b10; c.regw = 1'b1;
      return c;
   endfunction

   task automatic step(input ctl_t c);
      ctl = c;
      @(posedge clock);
      @(negedge clock);
   endtask

   // R0 <- v by shift-and-add while Instr is zero
   task automatic set_r0(input logic [31:0] v);
      step(c_r0(2'b10, 2'b10));
      step('0);
      for (int i = 31; i >= 0; i--) begin
         step(c_r0(2'b01, 2'b00));
         step('0);
         if (v[i]) begin
            step(c_r0(2'b01, 2'b11));
            step('0);
         end
      end
   endtask

   task automatic poke(input logic [31:0] addr, input logic [31:0] val);
      ctl_t c = '0;
      set_r0(addr);
      c.srca = 2'b01; c.srcb = 2'b10; c.ress = 2'b10; c.pcw = 1'b1;
      step(c);
      set_r0(val);
      c = '0;
      c.memw = 1'b1;
      step(c);
   endtask

   task automatic run_ldr();
      step(c_fetch());
      step(c_dec(2'b00));
      step(c_memadr(2'b00));
      step(c_memrd());
      step(c_ldwb());
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pc"}, dut.pc, 32'd0);
      check({tag, "_instr"}, instr_o, 32'd0);
      check({tag, "_flags"}, 32'(flags_o), 32'd0);
      check({tag, "_r0"}, 32'(r0_o), 32'd0);
      check({tag, "_r1"}, 32'(r1_o), 32'd0);
   endtask

   initial begin
      ctl_t c;
      step('0);
      reset  = 1'b0;
      chk_en = 1'b1;
      check_zero("rst");

      poke(32'd0,  32'hE591_1040);
      poke(32'd1,  32'hE592_2041);
      poke(32'd2,  32'hE021_0002);
      poke(32'd3,  32'hE593_3042);
      poke(32'd4,  32'hE053_3003);
      poke(32'd5,  32'hE580_1046);
      poke(32'd6,  32'hE081_0201);
      poke(32'd7,  32'h0000_0000);
      poke(32'd64, 32'h0000_005A);
      poke(32'd65, 32'h0000_003C);
      poke(32'd66, 32'h0000_0005);

      reset = 1'b1;
      step('0);
      reset = 1'b0;

      step(c_fetch());
      check("fetch_instr", instr_o, 32'hE591_1040);
      check("fetch_pc", dut.pc, 32'd1);
      step(c_dec(2'b00));
      step(c_memadr(2'b00));
      step(c_memrd());
      step(c_ldwb());
      check("ldr_r1", 32'(r1_o), 32'h5A);
      check("ldr_pc", dut.pc, 32'd1);

      run_ldr();
      step(c_fetch());
      step(c_dec(2'b00));
      step(c_exec(3'b110, 2'b00, 1'b0));
      step(c_dpwb());
      check("eor_r0", 32'(r0_o), 32'h66);
      check("eor_pc", dut.pc, 32'd3);

      step(c_dec(2'b00));
      step(c_exec(3'b000, 2'b00, 1'b0));
      step(c_dpwb());
      check("add_r0", 32'(r0_o), 32'h96);

      run_ldr();
      step(c_fetch());
      step(c_dec(2'b00));
      step(c_exec(3'b001, 2'b00, 1'b1));
      check("sub_flags", 32'(flags_o), 32'h6);
      step(c_exec(3'b000, 2'b00, 1'b0));
      check("hold_flags", 32'(flags_o), 32'h6);

      step(c_fetch());
      step(c_dec(2'b10));
      step(c_memadr(2'b10));
      step(c_store(2'b10));
      check("str_mem", dut.mem[220], 32'h5A);

      step(c_fetch());
      step(c_dec(2'b00));
      step(c_exec(3'b000, 2'b00, 1'b0));
      step(c_dpwb());
      check("lsl_r0", 32'(r0_o), 32'hFA);

      step(c_fetch());
      c = c_fetch();
      c.regw = 1'b1; c.flagu = 1'b1; c.memw = 1'b0;
      reset = 1'b1;
      step(c);
      reset = 1'b0;
      check_zero("mid");

      step(c_fetch());
      step(c_dec(2'b01));
      step(c_exec(3'b000, 2'b10, 1'b0));
      step(c_dpwb());
      check("r15_r1", 32'(r1_o), 32'd2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
